// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, opcode constants and instruction width.
package mips_pkg;

  localparam int INSN_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, bgtz-style relative branch or j-type jump.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        PCSrc,
  input  logic [15:0] imm,
  input  logic [25:0] target_address,
  input  logic        cond_met,
  output logic [31:0] next_pc
);

  logic        [31:0] pc4;
  logic signed [31:0] offset;

  assign pc4    = pc + 32'd4;
  // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
  assign offset = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    next_pc = pc4;
    if (branch && PCSrc)
      next_pc = {pc4[31:28], target_address, 2'b00};
    else if (branch && cond_met)
      next_pc = pc4 + $unsigned(offset);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds PC, fetches from variable-latency imem, hands words to the decoder.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [INSN_W-1:0] insc,
  output logic              insc_valid,
  input  logic              decode_ready,
  input  logic              branch,
  input  logic              PCSrc,
  input  logic [15:0]       imm,
  input  logic [25:0]       target_address,
  input  logic              cond_met,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic [31:0]       pc_out
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         handoff;

  assign imem_addr = pc[ADDR_W+1:2];
  assign handoff   = insc_valid && decode_ready;

  next_pc_calc u_next_pc (
    .pc             (pc),
    .branch         (branch),
    .PCSrc          (PCSrc),
    .imm            (imm),
    .target_address (target_address),
    .cond_met       (cond_met),
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      insc       <= '0;
      insc_valid <= 1'b0;
      pc_out     <= RESET_PC;
    end else begin
      case (state)
        // One dead cycle so an ack left over from an aborted fetch is dropped.
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            insc       <= imem_rdata;
            pc_out     <= pc;
            insc_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (handoff) begin
            pc         <= next_pc;
            insc_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_evt;

  assign stall_evt = ((state == FETCH) && !imem_ack) || ((state == HOLD) && !decode_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (handoff)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_evt)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a configurable-latency memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] insc;
  logic        insc_valid;
  logic        decode_ready;
  logic        branch;
  logic        PCSrc;
  logic [15:0] imm;
  logic [25:0] target_address;
  logic        cond_met;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        force_ack;
  int          mem_lat;
  int          mem_cnt;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .insc           (insc),
    .insc_valid     (insc_valid),
    .decode_ready   (decode_ready),
    .branch         (branch),
    .PCSrc          (PCSrc),
    .imm            (imm),
    .target_address (target_address),
    .cond_met       (cond_met),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .pc_out         (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after mem_lat request cycles, word = addi pattern tagged with address.
  always @(negedge clk) begin
    if (imem_req && rst_n) begin
      if (mem_cnt >= mem_lat) begin
        mem_ack   <= 1'b1;
        mem_rdata <= 32'h2008_0005 ^ ({22'd0, imem_addr} << 16);
        mem_cnt   <= 0;
      end else begin
        mem_ack <= 1'b0;
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_ack <= 1'b0;
      mem_cnt <= 0;
    end
  end

  assign imem_ack   = force_ack | mem_ack;
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_rdata;

  task automatic clear_dec();
    decode_ready   = 1'b0;
    branch         = 1'b0;
    PCSrc          = 1'b0;
    imm            = 16'h0;
    target_address = 26'h0;
    cond_met       = 1'b0;
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    clear_dec();
    mem_lat = lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (insc_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handoff(input logic b, input logic s, input logic [15:0] im,
                         input logic [25:0] ta, input logic c);
    branch = b; PCSrc = s; imm = im; target_address = ta; cond_met = c;
    decode_ready = 1'b1;
    @(negedge clk);
    clear_dec();
  endtask

  task automatic test_reset();
    @(negedge clk);
    mem_lat = 1000;
    clear_dec();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || insc_valid !== 1'b0 || pc_out !== 32'h0 || insc !== 32'h0) begin
      errors++;
      $display("FAIL reset_async req=%b valid=%b pc_out=%h insc=%h want 0/0/0/0", imem_req, insc_valid, pc_out, insc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || insc_valid !== 1'b0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold req=%b valid=%b pc_out=%h want 0/0/0", imem_req, insc_valid, pc_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_first_req req=%b addr=%h want 1/000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    int vcnt;
    do_reset(0);
    decode_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (insc_valid !== 1'b1 || insc !== 32'h2008_0005 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL seq_first valid=%b insc=%h pc_out=%h want 1/20080005/0", insc_valid, insc, pc_out);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd1) begin
      errors++;
      $display("FAIL seq_next_addr req=%b addr=%h want 1/001", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (insc_valid !== 1'b1 || pc_out !== 32'h4 || insc !== 32'h2009_0005) begin
      errors++;
      $display("FAIL seq_second valid=%b pc_out=%h insc=%h want 1/4/20090005", insc_valid, pc_out, insc);
    end
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (insc_valid) vcnt++;
    end
    checks++;
    if (vcnt != 4 || pc_out !== 32'h14) begin
      errors++;
      $display("FAIL seq_throughput valid_cycles=%0d pc_out=%h want 4/14", vcnt, pc_out);
    end
    clear_dec();
  endtask

  task automatic test_jump();
    bit ok;
    do_reset(0);
    wait_valid(ok);
    handoff(1'b1, 1'b1, 16'h0, 26'h000_0004, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h10) begin
      errors++;
      $display("FAIL jump_to_10 ok=%b pc_out=%h want 1/10", ok, pc_out);
    end
    handoff(1'b1, 1'b1, 16'h0, 26'h000_0040, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h040) begin
      errors++;
      $display("FAIL jump_addr req=%b addr=%h want 1/040", imem_req, imem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h100) begin
      errors++;
      $display("FAIL jump_pc ok=%b pc_out=%h want 1/100", ok, pc_out);
    end
    handoff(1'b1, 1'b1, 16'h0, 26'h3FF_FFFF, 1'b0);
    checks++;
    if (imem_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL jump_trunc addr=%h want 3ff", imem_addr);
    end
    wait_valid(ok);
    handoff(1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h1000_0000 || imem_addr !== 10'h000) begin
      errors++;
      $display("FAIL jump_seq_after ok=%b pc_out=%h addr=%h want 1/10000000/000", ok, pc_out, imem_addr);
    end
  endtask

  task automatic test_branch();
    bit ok;
    do_reset(0);
    wait_valid(ok);
    handoff(1'b1, 1'b1, 16'h0, 26'h000_0008, 1'b0);
    wait_valid(ok);
    handoff(1'b1, 1'b0, 16'hFFFE, 26'h3FF_FFFF, 1'b1);
    checks++;
    if (imem_addr !== 10'h007) begin
      errors++;
      $display("FAIL bgtz_taken_addr addr=%h want 007", imem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h1C) begin
      errors++;
      $display("FAIL bgtz_taken ok=%b pc_out=%h want 1/1c", ok, pc_out);
    end
    handoff(1'b0, 1'b1, 16'h0, 26'h3FF_FFFF, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h20) begin
      errors++;
      $display("FAIL branch_low_seq ok=%b pc_out=%h want 1/20", ok, pc_out);
    end
    handoff(1'b1, 1'b0, 16'hFFFE, 26'h0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h24) begin
      errors++;
      $display("FAIL bgtz_not_taken ok=%b pc_out=%h want 1/24", ok, pc_out);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(0);
    wait_valid(ok);
    handoff(1'b1, 1'b0, 16'hFFFE, 26'h0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'hFFFF_FFFC || insc !== (32'h2008_0005 ^ 32'h03FF_0000)) begin
      errors++;
      $display("FAIL wrap_neg ok=%b pc_out=%h insc=%h want 1/fffffffc/23f70005", ok, pc_out, insc);
    end
    handoff(1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL wrap_zero ok=%b pc_out=%h want 1/0", ok, pc_out);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] held;
    do_reset(4);
    wait_valid(ok);
    checks++;
    if (!ok || insc !== 32'h2008_0005) begin
      errors++;
      $display("FAIL stall_fetch ok=%b insc=%h want 1/20080005", ok, insc);
    end
    held = insc;
    for (int i = 0; i < 3; i++) begin
      branch = 1'b1; PCSrc = 1'b1; target_address = 26'h100;
      checks++;
      if (insc_valid !== 1'b1 || insc !== held || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d valid=%b insc=%h req=%b want 1/%h/0", i, insc_valid, insc, imem_req, held);
      end
      @(negedge clk);
    end
    mem_lat = 1000;
    handoff(1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    checks++;
    if (insc_valid !== 1'b0 || imem_addr !== 10'd1) begin
      errors++;
      $display("FAIL stall_handoff valid=%b addr=%h want 0/001", insc_valid, imem_addr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd7 || perf_fetch_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts stall=%0d fetch=%0d want 7/1", perf_stall_cnt, perf_fetch_cnt);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (insc_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_single valid=%b req=%b want 0/1", insc_valid, imem_req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    do_reset(0);
    wait_valid(ok);
    mem_lat = 1000;
    handoff(1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 10'd0) begin
      errors++;
      $display("FAIL midreset_async req=%b addr=%h want 0/000", imem_req, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    checks++;
    if (insc_valid !== 1'b0 || insc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      errors++;
      $display("FAIL midreset_stale valid=%b insc=%h req=%b addr=%h want 0/0/1/000", insc_valid, insc, imem_req, imem_addr);
    end
    mem_lat = 0;
    wait_valid(ok);
    checks++;
    if (!ok || insc !== 32'h2008_0005 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_refetch ok=%b insc=%h pc_out=%h want 1/20080005/0", ok, insc, pc_out);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    force_ack = 1'b0;
    mem_lat   = 1000;
    mem_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    clear_dec();
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_wrap();
    test_stall();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decoder. It holds the PC, requests instruction words from a variable-latency instruction memory and presents each word, with a valid flag, to the decoder. It then computes the next PC from the decoder's branch/jump outputs: sequential, bgtz-style conditional branch, or j-type jump.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
ADDR_W, 10, width of word address driven to instruction memory.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  ADDR_W  word address, equals pc[ADDR_W+1:2].
imem_ack  input  1  memory has rdata valid this cycle.
imem_rdata  input  32  instruction word, sampled only when imem_ack is high.
insc  output  32  instruction register to decoder.
insc_valid  output  1  insc holds a live instruction.
decode_ready  input  1  decoder consumes insc this cycle.
branch  input  1  decoder branch flag for the current insc.
PCSrc  input  1  decoder jump select; 1 means j-type.
imm  input  16  decoder immediate, branch offset in words.
target_address  input  26  decoder jump target field.
cond_met  input  1  branch condition result from ALU (bgtz: rs > 0).
pc_out  output  32  byte address of the instruction in insc.

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, state=IDLE, imem_req=0, insc=0, insc_valid=0, pc_out=RESET_PC. All of these take effect immediately, not at the next edge.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: one cycle after reset release, then go to FETCH. imem_ack is ignored in IDLE, so a stale ack from a fetch aborted by reset is dropped.
  - FETCH: imem_req=1, imem_addr stable. On imem_ack: insc<=imem_rdata, pc_out<=pc, insc_valid<=1, go to HOLD. With no ack, wait indefinitely with req held high.
  - HOLD: imem_req=0, insc and insc_valid held stable. On decode_ready: pc<=next_pc, insc_valid<=0, go to FETCH.
- Handoff occurs only when insc_valid and decode_ready are both high. branch, PCSrc, imm, target_address and cond_met are sampled only at handoff and ignored in all other cycles.
- Next-PC selection at handoff, with pc4 = pc+4:
  - branch & PCSrc gives {pc4[31:28], target_address, 2'b00}.
  - branch & ~PCSrc & cond_met gives pc4 + (sign_extend(imm) << 2).
  - Otherwise gives pc4.
- Arithmetic is modulo 2^32: pc 32'hFFFF_FFFC sequences to 32'h0000_0000. imem_addr silently truncates upper bits.
- Minimum latency:
  - ack arriving the cycle after req rises: insc_valid high 2 cycles after entering FETCH.
  - Back-to-back throughput with zero-wait memory and decode_ready tied high: one instruction per 2 cycles.
- imem_ack in HOLD is a protocol error and is ignored.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds two outputs, perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 asynchronously and wrapping at 2^32.
  - perf_fetch_cnt increments on every handoff.
  - perf_stall_cnt increments each cycle in FETCH with imem_ack low, or in HOLD with decode_ready low.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg: FSM state encoding (fetch_state_t: IDLE, FETCH, HOLD), opcode constants (OP_RTYPE 6'b000000, OP_J 6'b000010, OP_ADDI 6'b001000, OP_BGTZ 6'b000111, OP_LW 6'b100011, OP_SW 6'b101011), and INSN_W=32.
- One sub-module, next_pc_calc: purely combinational. Inputs are pc, branch, PCSrc, imm, target_address and cond_met; output is next_pc. It is reusable by a future pipelined branch unit.

Test Plan:
- Reset: hold rst_n low 3 cycles, RESET_PC=0 → imem_req=0, insc_valid=0, pc_out=0. After release: IDLE for 1 cycle, then imem_req=1, imem_addr=0.
- Sequential fetch: zero-wait memory returns 32'h2008_0005 (addi) at addr 0, decode_ready=1, branch=0 → next request at imem_addr=1 and pc_out=4 on the next valid; one instruction per 2 cycles.
- Jump: at pc=32'h0000_0010, handoff with branch=1, PCSrc=1, target_address=26'h000_0040 → next imem_addr=0x40, pc=32'h0000_0100.
- bgtz backward branch: pc=32'h20, branch=1, PCSrc=0, imm=16'hFFFE, cond_met=1 → pc=32'h1C. Same stimulus with cond_met=0 → pc=32'h24.
- Stalls: memory acks after 5 cycles and decode_ready is low for 3 cycles in HOLD → insc stable throughout and single handoff; with FETCH_PERF_EN defined, perf_stall_cnt=7 and perf_fetch_cnt=1.
- Reset mid-fetch: rst_n asserted while in FETCH, then imem_ack pulses during IDLE after release → ack ignored, insc_valid stays 0, and the fetch restarts at RESET_PC.
